// File: rtl/usb_stream_arbiter_pkg.sv
// Shared types and constants for the packet-granular USB stream arbiter.
package usb_stream_arbiter_package;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_HSADC = 2'd1,
        GRANT_XADC  = 2'd2
    } arb_state_t;

    typedef enum logic {
        HSADC = 1'b0,
        XADC  = 1'b1
    } arb_channel_t;

    localparam logic [7:0] COBS_DELIMITER = 8'h00;

    function automatic logic [1:0] grant_mask(arb_channel_t ch);
        return (ch == HSADC) ? 2'b01 : 2'b10;
    endfunction

    function automatic arb_state_t grant_state(arb_channel_t ch);
        return (ch == HSADC) ? GRANT_HSADC : GRANT_XADC;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream skid buffer: registered tvalid/tdata and registered tready,
// full throughput; the skid entry catches the byte in flight when the sink stalls.
module axis_skid_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready
);

    logic [DATA_W-1:0] skid_data;
    logic              skid_valid;
    logic              in_fire;
    logic              load_out;

    assign in_fire  = s_tvalid & s_tready;
    assign load_out = m_tready | ~m_tvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            s_tready   <= 1'b1;
        end else begin
            if (load_out) begin
                if (skid_valid) begin
                    m_tdata    <= skid_data;
                    m_tvalid   <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    m_tvalid <= in_fire;
                    if (in_fire) m_tdata <= s_tdata;
                end
            end else if (in_fire) begin
                skid_valid <= 1'b1;
                skid_data  <= s_tdata;
            end
            // Ready next cycle exactly when the skid entry will be empty.
            s_tready <= load_out | ~(skid_valid | in_fire);
        end
    end

endmodule

// File: rtl/usb_stream_arbiter.sv
// Round-robin, packet-granular merge of the HSADC and XADC COBS byte streams
// onto the single FT232H sink; ownership changes only after a delimiter.
module usb_stream_arbiter
    import usb_stream_arbiter_package::*;
#(
    parameter int COUNT_WIDTH      = 16,
    parameter int MAX_PACKET_BYTES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             hsadc_axis_tdata,
    input  logic                   hsadc_axis_tvalid,
    output logic                   hsadc_axis_tready,
    input  logic [7:0]             xadc_axis_tdata,
    input  logic                   xadc_axis_tvalid,
    output logic                   xadc_axis_tready,
    output logic [7:0]             usb_axis_tdata,
    output logic                   usb_axis_tvalid,
    input  logic                   usb_axis_tready,
    output logic                   usb_axis_tlast,
    input  logic [1:0]             enable,
    output logic [1:0]             grant,
    output logic [COUNT_WIDTH-1:0] hsadc_pkt_count,
    output logic [COUNT_WIDTH-1:0] xadc_pkt_count,
    output logic                   overrun,
    input  logic                   overrun_clear
);

    localparam int BCW = $clog2(MAX_PACKET_BYTES + 2);
    localparam logic [BCW-1:0] OVERRUN_AT = BCW'(MAX_PACKET_BYTES);
    localparam logic [BCW-1:0] BYTE_SAT   = BCW'(MAX_PACKET_BYTES + 1);

    arb_state_t   state;
    arb_channel_t last_grant;
    arb_channel_t next_ch;
    logic [BCW-1:0] byte_cnt;
    logic [1:0]   req;
    logic [7:0]   sel_data;
    logic         sel_valid;
    logic         skid_ready;
    logic         accept;
    logic         delim;
    logic         overrun_event;

    always_comb begin
        sel_valid         = 1'b0;
        sel_data          = hsadc_axis_tdata;
        hsadc_axis_tready = 1'b0;
        xadc_axis_tready  = 1'b0;
        case (state)
            GRANT_HSADC: begin
                sel_valid         = hsadc_axis_tvalid;
                sel_data          = hsadc_axis_tdata;
                hsadc_axis_tready = skid_ready;
            end
            GRANT_XADC: begin
                sel_valid        = xadc_axis_tvalid;
                sel_data         = xadc_axis_tdata;
                xadc_axis_tready = skid_ready;
            end
            default: ;
        endcase
    end

    assign req           = {xadc_axis_tvalid & enable[1], hsadc_axis_tvalid & enable[0]};
    assign accept        = sel_valid & skid_ready;
    assign delim         = accept & (sel_data == COBS_DELIMITER);
    assign overrun_event = accept & (byte_cnt == OVERRUN_AT);

    // On a tie the channel that did not own the previous packet wins.
    always_comb begin
        next_ch = req[0] ? HSADC : XADC;
        if (req == 2'b11) next_ch = (last_grant == HSADC) ? XADC : HSADC;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            last_grant      <= XADC;
            grant           <= 2'b00;
            byte_cnt        <= '0;
            hsadc_pkt_count <= '0;
            xadc_pkt_count  <= '0;
            overrun         <= 1'b0;
        end else begin
            if (overrun_event)      overrun <= 1'b1;
            else if (overrun_clear) overrun <= 1'b0;

            case (state)
                IDLE: begin
                    byte_cnt <= '0;
                    if (req != 2'b00) begin
                        state <= grant_state(next_ch);
                        grant <= grant_mask(next_ch);
                    end
                end
                default: begin
                    if (accept && byte_cnt != BYTE_SAT) byte_cnt <= byte_cnt + 1'b1;
                    if (delim) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        if (state == GRANT_HSADC) begin
                            last_grant      <= HSADC;
                            hsadc_pkt_count <= hsadc_pkt_count + 1'b1;
                        end else begin
                            last_grant     <= XADC;
                            xadc_pkt_count <= xadc_pkt_count + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    axis_skid_buffer #(.DATA_W(8)) u_out_skid (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (sel_data),
        .s_tvalid (sel_valid),
        .s_tready (skid_ready),
        .m_tdata  (usb_axis_tdata),
        .m_tvalid (usb_axis_tvalid),
        .m_tready (usb_axis_tready)
    );

    assign usb_axis_tlast = (usb_axis_tdata == COBS_DELIMITER);

endmodule

// File: tb/tb_usb_stream_arbiter.sv
// Directed bench for usb_stream_arbiter: queue-driven sources, byte-capturing sink.
module tb_usb_stream_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  hsadc_axis_tdata, xadc_axis_tdata, usb_axis_tdata;
    logic        hsadc_axis_tvalid, hsadc_axis_tready;
    logic        xadc_axis_tvalid, xadc_axis_tready;
    logic        usb_axis_tvalid, usb_axis_tready, usb_axis_tlast;
    logic [1:0]  enable, grant;
    logic [15:0] hsadc_pkt_count, xadc_pkt_count;
    logic        overrun, overrun_clear;

    int errors = 0;
    int checks = 0;

    logic [7:0] hq[$];
    logic [7:0] xq[$];
    logic [7:0] out_data[$];
    bit         out_last[$];
    int         h_acc = 0;
    int         x_acc = 0;
    int         stall_viol = 0;
    bit         bp_mode = 1'b0;

    always #5 clk = ~clk;

    usb_stream_arbiter #(.COUNT_WIDTH(16), .MAX_PACKET_BYTES(64)) dut (
        .clk               (clk),
        .rst               (rst),
        .hsadc_axis_tdata  (hsadc_axis_tdata),
        .hsadc_axis_tvalid (hsadc_axis_tvalid),
        .hsadc_axis_tready (hsadc_axis_tready),
        .xadc_axis_tdata   (xadc_axis_tdata),
        .xadc_axis_tvalid  (xadc_axis_tvalid),
        .xadc_axis_tready  (xadc_axis_tready),
        .usb_axis_tdata    (usb_axis_tdata),
        .usb_axis_tvalid   (usb_axis_tvalid),
        .usb_axis_tready   (usb_axis_tready),
        .usb_axis_tlast    (usb_axis_tlast),
        .enable            (enable),
        .grant             (grant),
        .hsadc_pkt_count   (hsadc_pkt_count),
        .xadc_pkt_count    (xadc_pkt_count),
        .overrun           (overrun),
        .overrun_clear     (overrun_clear)
    );

    // Handshakes are observed at negedge and applied right after the next posedge.
    initial begin
        bit h_fire, x_fire, prev_v, prev_r;
        logic [7:0] prev_d;
        prev_v = 1'b0; prev_r = 1'b0; prev_d = 8'h00;
        hsadc_axis_tvalid = 1'b0; hsadc_axis_tdata = 8'h00;
        xadc_axis_tvalid  = 1'b0; xadc_axis_tdata  = 8'h00;
        usb_axis_tready   = 1'b1;
        forever begin
            @(negedge clk);
            h_fire = hsadc_axis_tvalid && hsadc_axis_tready;
            x_fire = xadc_axis_tvalid && xadc_axis_tready;
            if (usb_axis_tvalid && usb_axis_tready) begin
                out_data.push_back(usb_axis_tdata);
                out_last.push_back(usb_axis_tlast);
            end
            if (rst) prev_v = 1'b0;
            else begin
                if (prev_v && !prev_r && (!usb_axis_tvalid || usb_axis_tdata !== prev_d))
                    stall_viol++;
                prev_v = usb_axis_tvalid; prev_r = usb_axis_tready; prev_d = usb_axis_tdata;
            end
            @(posedge clk);
            #1;
            if (h_fire && hq.size() > 0) begin void'(hq.pop_front()); h_acc++; end
            if (x_fire && xq.size() > 0) begin void'(xq.pop_front()); x_acc++; end
            hsadc_axis_tvalid = (hq.size() > 0);
            hsadc_axis_tdata  = (hq.size() > 0) ? hq[0] : 8'h00;
            xadc_axis_tvalid  = (xq.size() > 0);
            xadc_axis_tdata   = (xq.size() > 0) ? xq[0] : 8'h00;
            usb_axis_tready   = bp_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic clear_out();
        out_data.delete();
        out_last.delete();
    endtask

    task automatic wait_out(input int n, input int budget);
        int c = 0;
        while (out_data.size() < n && c < budget) begin tick(); c++; end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 2'b00; overrun_clear = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checks++; if (usb_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", usb_axis_tvalid); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if (hsadc_pkt_count !== 16'd0 || xadc_pkt_count !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", hsadc_pkt_count, xadc_pkt_count); end
        checks++; if (overrun !== 1'b0 || hsadc_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_overrun_tready: got %b/%b want 0/0", overrun, hsadc_axis_tready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] pkt [4];
        int base, c, bad;
        pkt = '{8'h03, 8'h11, 8'h22, 8'h00};
        clear_out(); enable = 2'b01; base = h_acc;
        foreach (pkt[i]) hq.push_back(pkt[i]);
        c = 0;
        while (h_acc == base && c < 20) begin tick(); c++; end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", grant); end
        wait_out(4, 20);
        checks++; if (out_data.size() !== 4) begin errors++; $display("FAIL single_len: got %0d want 4", out_data.size()); end
        bad = 0;
        for (int i = 0; i < 4 && i < out_data.size(); i++)
            if (out_data[i] !== pkt[i] || out_last[i] !== (i == 3)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL single_bytes: got %0d bad bytes want 0", bad); end
        checks++; if (hsadc_pkt_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", hsadc_pkt_count); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_idle_grant: got %b want 00", grant); end
    endtask

    task automatic test_mid_disable();
        logic [7:0] exp [8];
        int base, c, bad;
        exp = '{8'h04, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h02, 8'h77, 8'h00};
        clear_out(); enable = 2'b01; base = h_acc;
        for (int i = 0; i < 5; i++) hq.push_back(exp[i]);
        hq.push_back(8'h02); hq.push_back(8'h99); hq.push_back(8'h00);
        c = 0;
        while (h_acc - base < 2 && c < 20) begin tick(); c++; end
        enable = 2'b10;
        for (int i = 5; i < 8; i++) xq.push_back(exp[i]);
        wait_out(8, 40);
        repeat (5) tick();
        checks++; if (out_data.size() !== 8) begin errors++; $display("FAIL middis_len: got %0d want 8", out_data.size()); end
        bad = 0;
        for (int i = 0; i < 8 && i < out_data.size(); i++) if (out_data[i] !== exp[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL middis_bytes: got %0d bad want 0", bad); end
        checks++; if (hq.size() !== 3) begin errors++; $display("FAIL middis_hsadc_held: got %0d left want 3", hq.size()); end
        checks++; if (hsadc_pkt_count !== 16'd2 || xadc_pkt_count !== 16'd1) begin errors++; $display("FAIL middis_counts: got %0d/%0d want 2/1", hsadc_pkt_count, xadc_pkt_count); end
        hq.delete();
        repeat (2) tick();
    endtask

    task automatic overrun_packet(input bit hold_clear);
        int base, c, bad;
        bit seen64, seen65;
        clear_out(); enable = 2'b01; seen64 = 0; seen65 = 0;
        overrun_clear = 1'b1; tick(); overrun_clear = hold_clear;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre: got %b want 0", overrun); end
        base = h_acc;
        for (int i = 0; i < 70; i++) hq.push_back(8'(i + 1));
        hq.push_back(8'h00);
        c = 0;
        while (h_acc - base < 66 && c < 200) begin
            tick(); c++;
            if (h_acc - base == 64 && !seen64) begin
                seen64 = 1;
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_at64: got %b want 0", overrun); end
            end
            if (h_acc - base == 65 && !seen65) begin
                seen65 = 1;
                checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_at65 clr=%0d: got %b want 1", hold_clear, overrun); end
                if (hold_clear) begin
                    tick();
                    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_held_clear: got %b want 0", overrun); end
                end
            end
        end
        checks++; if (!(seen64 && seen65)) begin errors++; $display("FAIL ovr_stream: got seen %0d%0d want 11", seen64, seen65); end
        overrun_clear = 1'b0;
        wait_out(71, 200);
        checks++; if (out_data.size() !== 71) begin errors++; $display("FAIL ovr_len: got %0d want 71", out_data.size()); end
        bad = 0;
        for (int i = 0; i < 71 && i < out_data.size(); i++)
            if (out_data[i] !== ((i == 70) ? 8'h00 : 8'(i + 1)) || out_last[i] !== (i == 70)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL ovr_bytes: got %0d bad want 0", bad); end
    endtask

    task automatic test_overrun();
        overrun_packet(1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        overrun_clear = 1'b1; tick(); overrun_clear = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        overrun_packet(1'b1);
    endtask

    task automatic test_async_reset();
        int base, c;
        clear_out(); enable = 2'b01; base = h_acc;
        for (int i = 1; i < 10; i++) hq.push_back(8'(i));
        hq.push_back(8'h00);
        c = 0;
        while (h_acc - base < 3 && c < 20) begin tick(); c++; end
        checks++; if (usb_axis_tvalid !== 1'b1) begin errors++; $display("FAIL arst_pre_tvalid: got %b want 1", usb_axis_tvalid); end
        #1 rst = 1'b1;
        #1;
        checks++; if (usb_axis_tvalid !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL arst_outputs: got %b/%b want 0/00", usb_axis_tvalid, grant); end
        checks++; if (hsadc_pkt_count !== 16'd0 || xadc_pkt_count !== 16'd0) begin errors++; $display("FAIL arst_counts: got %0d/%0d want 0/0", hsadc_pkt_count, xadc_pkt_count); end
        hq.delete(); xq.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        clear_out();
    endtask

    // Both queues stay full, so ownership must alternate packet by packet.
    task automatic run_contention(input int npkt, input bit random_len, input int budget, input string tag);
        logic [7:0] exp[$];
        int bad, lastbad, len;
        logic [7:0] b;
        clear_out(); enable = 2'b11;
        for (int k = 0; k < npkt; k++) begin
            for (int s = 0; s < 2; s++) begin
                len = random_len ? $urandom_range(1, 8) : 3;
                for (int i = 0; i < len; i++) begin
                    b = random_len ? 8'($urandom_range(1, 255)) : ((i == 0) ? 8'h03 : (i == 1) ? 8'(k + 1) : (s == 0) ? 8'hA5 : 8'h5A);
                    if (s == 0) hq.push_back(b); else xq.push_back(b);
                    exp.push_back(b);
                end
                if (s == 0) hq.push_back(8'h00); else xq.push_back(8'h00);
                exp.push_back(8'h00);
            end
        end
        wait_out(exp.size(), budget);
        checks++; if (out_data.size() !== exp.size()) begin errors++; $display("FAIL %s_len: got %0d want %0d", tag, out_data.size(), exp.size()); end
        bad = 0; lastbad = 0;
        for (int i = 0; i < exp.size() && i < out_data.size(); i++) begin
            if (out_data[i] !== exp[i]) bad++;
            if (out_last[i] !== (exp[i] == 8'h00)) lastbad++;
        end
        checks++; if (bad !== 0 || lastbad !== 0) begin errors++; $display("FAIL %s_order: got %0d bad bytes %0d bad tlast want 0/0", tag, bad, lastbad); end
    endtask

    task automatic test_contention();
        run_contention(50, 1'b0, 2000, "contention");
        checks++; if (out_data.size() > 2 && out_data[2] !== 8'hA5) begin errors++; $display("FAIL first_tie_hsadc: got %0h want a5", out_data[2]); end
        checks++; if (hsadc_pkt_count !== 16'd50 || xadc_pkt_count !== 16'd50) begin errors++; $display("FAIL contention_counts: got %0d/%0d want 50/50", hsadc_pkt_count, xadc_pkt_count); end
    endtask

    task automatic test_back_to_back_backpressure();
        stall_viol = 0; bp_mode = 1'b1;
        run_contention(20, 1'b1, 6000, "backpressure");
        bp_mode = 1'b0;
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_tvalid_hold: got %0d violations want 0", stall_viol); end
        checks++; if (hsadc_pkt_count !== 16'd70 || xadc_pkt_count !== 16'd70) begin errors++; $display("FAIL bp_counts: got %0d/%0d want 70/70", hsadc_pkt_count, xadc_pkt_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mid_disable();
        test_overrun();
        test_async_reset();
        test_contention();
        test_back_to_back_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
